commit_tracer: RTL and testbench
================================

COMMIT_TRACER -- requirements
Module: commit_tracer

Interface
REQ-001 Parameter DEPTH, default 8, trace FIFO depth in records; power of two, at least 4.
REQ-002 Port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-003 Port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 Commit inputs, driven by the CPU commit port: commit 1, commit_pc 32, commit_inst 32, commit_halt 1, commit_reg_we 1, commit_reg_wa 5, commit_reg_wd 32, commit_dmem_we 1, commit_dmem_wa 32, commit_dmem_wd 32.
REQ-005 Port cpu_en, output, 1 bit: drives the CPU global_en.
REQ-006 Trace read side: trace_valid out 1, trace_ready in 1, and trace_* outputs mirroring every REQ-004 field except commit.
REQ-007 Ports shadow_ra in 5 and shadow_rd out 32: shadow register file read port.
REQ-008 Status outputs: inst_count 32, halted 1, overflow 1 (sticky).

Function
REQ-009 Capture condition: commit==1 AND cpu_en_q==1, where cpu_en_q is cpu_en registered one cycle earlier; commit held high across CPU stall cycles is never re-captured.
REQ-010 Each capture pushes one record (all REQ-004 fields except commit) into the FIFO in the same cycle.
REQ-011 FIFO is first-word-fall-through: trace_* show the head record whenever trace_valid==1; a pop occurs on trace_valid && trace_ready.
REQ-012 Simultaneous push and pop is legal at any occupancy, including full; occupancy is unchanged.
REQ-013 A push while full with no pop drops the record and sets overflow; overflow clears only on reset.
REQ-014 cpu_en = (state==RUN) AND (occupancy <= DEPTH-2), evaluated combinationally from registered state, so one in-flight commit always has room.
REQ-015 States: IDLE (after reset), RUN, HALTED. IDLE->RUN on the first cycle after rst deasserts. RUN->HALTED on a capture with commit_halt==1. HALTED persists until reset.
REQ-016 The halt record is enqueued normally; in HALTED, cpu_en==0, no further captures occur, and the FIFO still drains.
REQ-017 halted==1 exactly when state==HALTED.
REQ-018 inst_count increments by 1 per capture, 32-bit, wrapping from 0xFFFFFFFF to 0.
REQ-019 Shadow RF: 32x32. On a capture with commit_reg_we==1 and commit_reg_wa!=0, entry commit_reg_wa is written with commit_reg_wd at that edge.
REQ-020 shadow_rd is a combinational read: 0 for shadow_ra==0; otherwise the stored value, showing the pre-write value during a same-cycle write.
REQ-021 Field widths are preserved exactly; no sign or zero extension.

Reset
REQ-022 On rst==1 at a clock edge: state=IDLE, FIFO empty, trace_valid=0, cpu_en_q=0, inst_count=0, overflow=0, and all shadow RF entries=0.
REQ-023 During and in the cycle after reset, cpu_en=0 and trace_* data outputs read 0.
REQ-024 Reset mid-operation discards every buffered record; no partial record is emitted.

Configuration
REQ-025 Macro COMMIT_TRACER_SHADOW_RF_EN.
- Defined: the shadow RF is built as in REQ-019/020.
- Undefined: no shadow storage is built, shadow_rd is constant 0, and all other behaviour is unchanged.

Verification
REQ-026 Reset, then 3 commits (pc 0x00400000/4/8) with trace_ready=1 -> 3 records in order, inst_count=3, overflow=0.
REQ-027 commit held high for 4 cycles while cpu_en==0 -> exactly one record captured.
REQ-028 trace_ready=0, DEPTH=8 -> cpu_en drops at occupancy 7; the in-flight commit fills slot 8; overflow stays 0; then trace_ready=1 -> 8 records drain in order.
REQ-029 Capture with reg_we=1, wa=5, wd=0xDEADBEEF, then shadow_ra=5 -> 0xDEADBEEF (0 when the macro is undefined); wa=0 write -> shadow_rd for ra 0 stays 0.
REQ-030 Commit with commit_halt=1 and inst 0x00100073 -> halted=1, cpu_en=0, halt record is last out; rst -> IDLE, FIFO empty, inst_count=0.
REQ-031 Forced push when full with cpu_en overridden -> record dropped, overflow=1 until reset.

Source files
------------

// File: rtl/commit_tracer.sv
// Commit tracer: records CPU commits into a FWFT trace FIFO, optional shadow RF (COMMIT_TRACER_SHADOW_RF_EN).
// Latency: a capture is visible on trace_* the cycle after its commit edge; shadow RF write lands at that edge.
// Backpressure: trace_valid/trace_ready; cpu_en drops at occupancy DEPTH-1 so the in-flight commit always fits.

module commit_tracer_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             head_dat,
  output logic                     vld,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign vld      = (count != '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop && vld;
  // When full, a same-cycle pop frees the head slot the write lands in.
  assign do_push  = push && (!full || do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module commit_tracer #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit,
  input  logic [31:0] commit_pc,
  input  logic [31:0] commit_inst,
  input  logic        commit_halt,
  input  logic        commit_reg_we,
  input  logic [4:0]  commit_reg_wa,
  input  logic [31:0] commit_reg_wd,
  input  logic        commit_dmem_we,
  input  logic [31:0] commit_dmem_wa,
  input  logic [31:0] commit_dmem_wd,
  output logic        cpu_en,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_inst,
  output logic        trace_halt,
  output logic        trace_reg_we,
  output logic [4:0]  trace_reg_wa,
  output logic [31:0] trace_reg_wd,
  output logic        trace_dmem_we,
  output logic [31:0] trace_dmem_wa,
  output logic [31:0] trace_dmem_wd,
  input  logic [4:0]  shadow_ra,
  output logic [31:0] shadow_rd,
  output logic [31:0] inst_count,
  output logic        halted,
  output logic        overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] EN_LIMIT = (AW+1)'(DEPTH - 2);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        halt;
    logic        reg_we;
    logic [4:0]  reg_wa;
    logic [31:0] reg_wd;
    logic        dmem_we;
    logic [31:0] dmem_wa;
    logic [31:0] dmem_wd;
  } rec_t;

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t      state;
  logic        cpu_en_q;
  logic        capture;
  logic        pop;
  logic        fifo_full;
  logic [AW:0] fifo_count;
  rec_t        in_rec;
  rec_t        head_raw;
  rec_t        head_rec;

  // cpu_en_q marks a commit produced by an enabled CPU cycle; stalled repeats are ignored.
  assign capture = commit && cpu_en_q && (state == RUN);
  assign cpu_en  = (state == RUN) && (fifo_count <= EN_LIMIT);
  assign pop     = trace_valid && trace_ready;
  assign halted  = (state == HALTED);

  assign in_rec = '{pc: commit_pc, inst: commit_inst, halt: commit_halt,
                    reg_we: commit_reg_we, reg_wa: commit_reg_wa, reg_wd: commit_reg_wd,
                    dmem_we: commit_dmem_we, dmem_wa: commit_dmem_wa, dmem_wd: commit_dmem_wd};

  commit_tracer_fifo #(.W($bits(rec_t)), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (capture),
    .push_dat (in_rec),
    .pop      (pop),
    .head_dat (head_raw),
    .vld      (trace_valid),
    .full     (fifo_full),
    .count    (fifo_count)
  );

  // Stale RAM contents never reach the trace outputs.
  assign head_rec      = trace_valid ? head_raw : '0;
  assign trace_pc      = head_rec.pc;
  assign trace_inst    = head_rec.inst;
  assign trace_halt    = head_rec.halt;
  assign trace_reg_we  = head_rec.reg_we;
  assign trace_reg_wa  = head_rec.reg_wa;
  assign trace_reg_wd  = head_rec.reg_wd;
  assign trace_dmem_we = head_rec.dmem_we;
  assign trace_dmem_wa = head_rec.dmem_wa;
  assign trace_dmem_wd = head_rec.dmem_wd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cpu_en_q   <= 1'b0;
      inst_count <= '0;
      overflow   <= 1'b0;
    end else begin
      cpu_en_q <= cpu_en;
      if (capture) inst_count <= inst_count + 32'd1;
      if (capture && fifo_full && !pop) overflow <= 1'b1;
      case (state)
        IDLE:    state <= RUN;
        RUN:     if (capture && commit_halt) state <= HALTED;
        default: state <= HALTED;
      endcase
    end
  end

`ifdef COMMIT_TRACER_SHADOW_RF_EN
  logic [31:0] shadow [32];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) shadow[i] <= '0;
    end else if (capture && commit_reg_we && (commit_reg_wa != 5'd0)) begin
      shadow[commit_reg_wa] <= commit_reg_wd;
    end
  end

  assign shadow_rd = (shadow_ra == 5'd0) ? '0 : shadow[shadow_ra];
`else
  logic unused_shadow_ra;
  assign unused_shadow_ra = ^shadow_ra;
  assign shadow_rd        = '0;
`endif
endmodule

// File: tb/tb_commit_tracer.sv
// Bench for commit_tracer: queue-based reference model checked every cycle, plus literal checkpoints.
module tb_commit_tracer;
  localparam int DEPTH = 8;
`ifdef COMMIT_TRACER_SHADOW_RF_EN
  localparam bit SH_EN = 1'b1;
`else
  localparam bit SH_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        halt;
    logic        reg_we;
    logic [4:0]  reg_wa;
    logic [31:0] reg_wd;
    logic        dmem_we;
    logic [31:0] dmem_wa;
    logic [31:0] dmem_wd;
  } tr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit;
  tr_t         cur;
  logic        cpu_en, trace_valid, trace_ready;
  logic [31:0] trace_pc, trace_inst, trace_reg_wd, trace_dmem_wa, trace_dmem_wd;
  logic        trace_halt, trace_reg_we, trace_dmem_we;
  logic [4:0]  trace_reg_wa;
  logic [4:0]  shadow_ra;
  logic [31:0] shadow_rd, inst_count;
  logic        halted, overflow;
  tr_t         dut_tr;

  always #5 clk = ~clk;

  commit_tracer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .commit(commit),
    .commit_pc(cur.pc), .commit_inst(cur.inst), .commit_halt(cur.halt),
    .commit_reg_we(cur.reg_we), .commit_reg_wa(cur.reg_wa), .commit_reg_wd(cur.reg_wd),
    .commit_dmem_we(cur.dmem_we), .commit_dmem_wa(cur.dmem_wa), .commit_dmem_wd(cur.dmem_wd),
    .cpu_en(cpu_en), .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_inst(trace_inst), .trace_halt(trace_halt),
    .trace_reg_we(trace_reg_we), .trace_reg_wa(trace_reg_wa), .trace_reg_wd(trace_reg_wd),
    .trace_dmem_we(trace_dmem_we), .trace_dmem_wa(trace_dmem_wa), .trace_dmem_wd(trace_dmem_wd),
    .shadow_ra(shadow_ra), .shadow_rd(shadow_rd),
    .inst_count(inst_count), .halted(halted), .overflow(overflow)
  );

  assign dut_tr = {trace_pc, trace_inst, trace_halt, trace_reg_we, trace_reg_wa,
                   trace_reg_wd, trace_dmem_we, trace_dmem_wa, trace_dmem_wd};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [167:0] act, input logic [167:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Reference model: 0=idle 1=run 2=halted; queue holds buffered records.
  tr_t         mq[$];
  int          st = 0;
  bit          en_q = 0;
  bit          force_en = 0;
  bit          armed = 0;
  logic [31:0] m_cnt = 0;
  bit          m_ovf = 0;
  logic [31:0] m_rf[32];
  logic [31:0] got_pc[$];
  logic [31:0] got_inst[$];

  always @(posedge clk) begin : model
    bit exp_en, do_pop, cap;
    exp_en = (st == 1) && (mq.size() <= DEPTH - 2);
    if (rst) begin
      mq.delete();
      st = 0; en_q = 0; m_cnt = 0; m_ovf = 0; armed = 1;
      foreach (m_rf[i]) m_rf[i] = 0;
    end else begin
      do_pop = (mq.size() > 0) && trace_ready;
      cap    = commit && (en_q || force_en) && (st == 1);
      if (do_pop) void'(mq.pop_front());
      if (cap) begin
        if (mq.size() < DEPTH) mq.push_back(cur);
        else m_ovf = 1;
        m_cnt = m_cnt + 1;
        if (cur.reg_we && cur.reg_wa != 0) m_rf[cur.reg_wa] = cur.reg_wd;
      end
      if (st == 0) st = 1;
      else if (cap && cur.halt) st = 2;
      en_q = exp_en;
    end
  end

  always @(negedge clk) begin : compare
    tr_t         e_tr;
    logic [31:0] e_sh;
    if (armed) begin
      e_tr = (mq.size() > 0) ? mq[0] : '0;
      e_sh = (SH_EN && shadow_ra != 0) ? m_rf[shadow_ra] : 32'd0;
      chk("trace_valid", trace_valid, mq.size() > 0);
      chk("trace_rec",   dut_tr, e_tr);
      chk("cpu_en",      cpu_en, (st == 1) && (mq.size() <= DEPTH - 2));
      chk("inst_count",  inst_count, m_cnt);
      chk("halted",      halted, st == 2);
      chk("overflow",    overflow, m_ovf);
      chk("shadow_rd",   shadow_rd, e_sh);
      if (trace_valid && trace_ready) begin
        got_pc.push_back(trace_pc);
        got_inst.push_back(trace_inst);
      end
    end
  end

  tr_t tbl[$];
  int  tbl_idx;

  function automatic tr_t mk(input logic [31:0] pc, input logic [31:0] inst, input logic halt,
                             input logic we, input logic [4:0] wa, input logic [31:0] wd);
    tr_t t;
    t = '{pc: pc, inst: inst, halt: halt, reg_we: we, reg_wa: wa, reg_wd: wd,
          dmem_we: pc[2], dmem_wa: ~pc, dmem_wd: inst ^ 32'hA5A5_5A5A};
    return t;
  endfunction

  task automatic do_reset();
    rst = 1'b1; commit = 1'b0; force_en = 0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    got_pc.delete(); got_inst.delete();
  endtask

  // Emulated CPU: advances only after a cycle with cpu_en high, otherwise holds its commit.
  task automatic run_cpu(input int n);
    bit en_seen;
    for (int c = 0; c < n; c++) begin
      @(negedge clk); en_seen = cpu_en;
      @(posedge clk); #2;
      if (en_seen) begin
        if (tbl_idx < tbl.size()) begin
          cur = tbl[tbl_idx]; commit = 1'b1; tbl_idx++;
        end else begin
          commit = 1'b0;
        end
      end
    end
  endtask

  initial begin
    cur = '0; trace_ready = 1'b0; shadow_ra = 5'd0;
    do_reset();
    @(negedge clk);
    chk("rst_cpu_en", cpu_en, 1'b0);
    chk("rst_valid", trace_valid, 1'b0);

    // Three in-order commits with shadow writes, including a write to r0.
    trace_ready = 1'b1; shadow_ra = 5'd5;
    tbl = '{mk(32'h0040_0000, 32'h0000_0013, 0, 1, 5, 32'hDEAD_BEEF),
            mk(32'h0040_0004, 32'h0000_0033, 0, 1, 0, 32'h1234_5678),
            mk(32'h0040_0008, 32'h0000_0063, 0, 0, 5, 32'hFFFF_FFFF)};
    tbl_idx = 0;
    run_cpu(12);
    @(negedge clk);
    chk("t1_count", got_pc.size(), 3);
    chk("t1_pc0", got_pc[0], 32'h0040_0000);
    chk("t1_pc1", got_pc[1], 32'h0040_0004);
    chk("t1_pc2", got_pc[2], 32'h0040_0008);
    chk("t1_inst_count", inst_count, 32'd3);
    chk("t1_overflow", overflow, 1'b0);
    chk("t1_shadow5", shadow_rd, SH_EN ? 32'hDEAD_BEEF : 32'd0);
    shadow_ra = 5'd0;
    @(negedge clk);
    chk("t1_shadow0", shadow_rd, 32'd0);

    // Backpressure: FIFO fills to DEPTH, held commit captured only once, then drains in order.
    do_reset();
    trace_ready = 1'b0;
    tbl.delete();
    for (int i = 0; i < 10; i++) tbl.push_back(mk(32'h1000 + 32'(4*i), 32'(i), 0, 0, 0, 0));
    tbl_idx = 0;
    run_cpu(20);
    @(negedge clk);
    chk("t2_fill_count", inst_count, 32'd8);
    chk("t2_cpu_en_off", cpu_en, 1'b0);
    chk("t2_no_overflow", overflow, 1'b0);
    trace_ready = 1'b1;
    run_cpu(30);
    @(negedge clk);
    chk("t2_drained", got_pc.size(), 10);
    for (int i = 0; i < 10; i++) chk("t2_order", got_pc[i], 32'h1000 + 32'(4*i));
    chk("t2_overflow", overflow, 1'b0);

    // Forced push while full: dropped record, sticky overflow.
    do_reset();
    trace_ready = 1'b0;
    tbl.delete();
    for (int i = 0; i < 8; i++) tbl.push_back(mk(32'h2000 + 32'(4*i), 32'(i), 0, 0, 0, 0));
    tbl_idx = 0;
    run_cpu(20);
    @(posedge clk); #2;
    cur = mk(32'h0000_BAD0, 32'h0BAD, 0, 0, 0, 0); commit = 1'b1;
    force dut.cpu_en_q = 1'b1; force_en = 1;
    @(posedge clk); #2;
    commit = 1'b0; release dut.cpu_en_q; force_en = 0;
    @(negedge clk);
    chk("t3_overflow", overflow, 1'b1);
    chk("t3_count", inst_count, 32'd9);
    trace_ready = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("t3_drained", got_pc.size(), 8);
    chk("t3_last", got_pc[7], 32'h0000_201C);
    chk("t3_sticky", overflow, 1'b1);

    // Halt: halt record last out, later commit ignored, reset clears.
    do_reset();
    @(negedge clk);
    chk("t4_ovf_cleared", overflow, 1'b0);
    trace_ready = 1'b1; shadow_ra = 5'd6;
    tbl = '{mk(32'h3000, 32'h0000_0013, 0, 0, 0, 0),
            mk(32'h3004, 32'h0050_0293, 0, 1, 5, 32'd5),
            mk(32'h3008, 32'h0010_0073, 1, 0, 0, 0),
            mk(32'h300C, 32'h0000_0013, 0, 1, 6, 32'h66)};
    tbl_idx = 0;
    run_cpu(15);
    @(negedge clk);
    chk("t4_halted", halted, 1'b1);
    chk("t4_cpu_en", cpu_en, 1'b0);
    chk("t4_count", inst_count, 32'd3);
    chk("t4_records", got_inst.size(), 3);
    chk("t4_last_halt", got_inst[2], 32'h0010_0073);
    chk("t4_no_r6", shadow_rd, 32'd0);
    do_reset();
    @(negedge clk);
    chk("t4_rst_halted", halted, 1'b0);
    chk("t4_rst_count", inst_count, 32'd0);

    // Reset with records buffered discards them all.
    trace_ready = 1'b0;
    tbl = '{mk(32'h4000, 32'h1, 0, 0, 0, 0), mk(32'h4004, 32'h2, 0, 0, 0, 0),
            mk(32'h4008, 32'h3, 0, 0, 0, 0)};
    tbl_idx = 0;
    run_cpu(8);
    @(negedge clk);
    chk("t5_buffered", trace_valid, 1'b1);
    do_reset();
    @(negedge clk);
    chk("t5_valid", trace_valid, 1'b0);
    chk("t5_pc", trace_pc, 32'd0);
    chk("t5_cpu_en", cpu_en, 1'b0);
    @(negedge clk);
    chk("t5_run", cpu_en, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
